// File: rtl/l0_ctrl_pkg.sv
// l0_ctrl_pkg: shared definitions for the L0 input-buffer sequencer.
//   - l0_state_e : FSM state encoding (IDLE=0 .. DONE=4)
//   - Def*       : default geometry used as parameter defaults by l0_ctrl
package l0_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLoad  = 3'd1,
      StDrain = 3'd2,
      StFlush = 3'd3,
      StDone  = 3'd4
   } l0_state_e;

   localparam int unsigned DefRow      = 8;
   localparam int unsigned DefDepth    = 64;
   localparam int unsigned DefAw       = 11;
   localparam int unsigned DefLw       = 11;
   localparam int unsigned DefPrefetch = 16;

endpackage

// File: rtl/l0_ctrl_cnt.sv
// l0_ctrl_cnt: loadable up-counter with terminal-count flag.
// Ports:
//   clk        in  clock
//   reset      in  synchronous, active-high; clears the count
//   i_load     in  load i_load_val (has priority over i_en)
//   i_load_val in  value loaded on i_load
//   i_en       in  increment by one
//   i_last     in  terminal value
//   o_cnt      out current count
//   o_tc       out count equals i_last
module l0_ctrl_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   input  logic [W-1:0] i_last,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == i_last);

endmodule

// File: rtl/l0_ctrl.sv
// l0_ctrl: sequencer for the L0 input buffer (Row FIFOs, shared write, staggered read).
// LOAD streams len vectors from activation SRAM into L0, DRAIN issues one contiguous
// len-cycle read burst, FLUSH waits Row+1 cycles for the stagger to clear, DONE pulses.
// Only strobes and addresses are produced; SRAM read data goes straight to L0.
//
// Build option: define L0_CTRL_OVERLAP_EN to let DRAIN start once min(len, Prefetch)
// vectors are written while LOAD continues, and to accept any nonzero len.
//
// Ports:
//   clk          in  clock
//   reset        in  synchronous, active-high
//   i_start      in  single-cycle request, sampled only in IDLE
//   i_len        in  vector count, sampled with i_start
//   i_base_addr  in  first SRAM address, sampled with i_start
//   o_mem_rd     out SRAM read strobe (1-cycle read latency)
//   o_mem_addr   out SRAM read address
//   o_l0_wr      out L0 write strobe (o_mem_rd delayed one cycle)
//   o_l0_rd      out L0 read request
//   i_l0_full    in  any L0 row full
//   i_l0_ready   in  no L0 row full
//   o_busy       out high in every state except IDLE
//   o_done       out one-cycle completion pulse
//   o_err        out sticky error; cleared by reset or an accepted start
module l0_ctrl
   import l0_ctrl_pkg::*;
#(
   parameter int unsigned Row      = DefRow,
   parameter int unsigned Depth    = DefDepth,
   parameter int unsigned Aw       = DefAw,
   parameter int unsigned Lw       = DefLw,
   parameter int unsigned Prefetch = DefPrefetch
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_start,
   input  logic [Lw-1:0] i_len,
   input  logic [Aw-1:0] i_base_addr,
   output logic          o_mem_rd,
   output logic [Aw-1:0] o_mem_addr,
   output logic          o_l0_wr,
   output logic          o_l0_rd,
   input  logic          i_l0_full,
   input  logic          i_l0_ready,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err
);

   localparam int unsigned FlushW = $clog2(Row + 2);
   localparam logic [Lw-1:0] DepthLen    = Lw'(Depth);
   localparam logic [Lw-1:0] PrefetchLen = Lw'(Prefetch);
   localparam logic [FlushW-1:0] FlushLast = FlushW'(Row);

`ifdef L0_CTRL_OVERLAP_EN
   if (Prefetch + Row + 2 > Depth) begin : g_bad_cfg
      $error("l0_ctrl: Prefetch + Row + 2 must not exceed Depth");
   end
`endif

   l0_state_e       r_state;
   l0_state_e       w_state_nxt;
   logic [Lw-1:0]   r_len;
   logic [Aw-1:0]   r_addr;
   logic            r_l0_wr;
   logic            r_err;

   logic            w_accept;
   logic            w_reject;
   logic            w_len_ok;
   logic            w_mem_rd;
   logic            w_l0_rd;
   logic            w_flush_en;
   logic [Lw-1:0]   w_thr;

   logic [Lw-1:0]     w_load_cnt;
   logic              w_load_tc;
   logic [Lw-1:0]     w_drain_cnt;
   logic              w_drain_tc;
   logic [FlushW-1:0] w_flush_cnt;
   logic              w_flush_tc;
   logic              w_unused;

`ifdef L0_CTRL_OVERLAP_EN
   assign w_len_ok = (i_len != '0);
   // Reads may start once this many writes have landed in L0.
   assign w_thr    = (r_len < PrefetchLen) ? r_len : PrefetchLen;
   assign w_unused = ^{w_drain_cnt, w_flush_cnt};
`else
   assign w_len_ok = (i_len != '0) && (i_len <= DepthLen);
   assign w_thr    = r_len;
   assign w_unused = ^{w_drain_cnt, w_flush_cnt, PrefetchLen};
`endif

   // Counts reads issued; writes completed by the end of this cycle equal this count.
   l0_ctrl_cnt #(.W(Lw)) u_load_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_accept),
      .i_load_val ('0),
      .i_en       (w_mem_rd),
      .i_last     (r_len),
      .o_cnt      (w_load_cnt),
      .o_tc       (w_load_tc)
   );

   l0_ctrl_cnt #(.W(Lw)) u_drain_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_accept),
      .i_load_val ('0),
      .i_en       (w_l0_rd),
      .i_last     (r_len - 1'b1),
      .o_cnt      (w_drain_cnt),
      .o_tc       (w_drain_tc)
   );

   l0_ctrl_cnt #(.W(FlushW)) u_flush_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_accept),
      .i_load_val ('0),
      .i_en       (w_flush_en),
      .i_last     (FlushLast),
      .o_cnt      (w_flush_cnt),
      .o_tc       (w_flush_tc)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_reject    = 1'b0;
      w_mem_rd    = 1'b0;
      w_l0_rd     = 1'b0;
      w_flush_en  = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_start) begin
               if (w_len_ok && i_l0_ready) begin
                  w_accept    = 1'b1;
                  w_state_nxt = StLoad;
               end else begin
                  w_reject = 1'b1;
               end
            end
         end
         StLoad: begin
            w_mem_rd = !w_load_tc;
            // Enter DRAIN the cycle after the threshold write has issued.
            if (w_load_cnt >= w_thr) begin
               w_state_nxt = StDrain;
            end
         end
         StDrain: begin
            w_mem_rd = !w_load_tc;
            w_l0_rd  = 1'b1;
            if (w_drain_tc && w_load_tc) begin
               w_state_nxt = StFlush;
            end
         end
         StFlush: begin
            w_flush_en = 1'b1;
            if (w_flush_tc) begin
               w_state_nxt = StDone;
            end
         end
         StDone: begin
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
         r_len   <= '0;
         r_addr  <= '0;
         r_l0_wr <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_l0_wr <= w_mem_rd;
         if (w_accept) begin
            r_len  <= i_len;
            r_addr <= i_base_addr;
         end else if (w_mem_rd) begin
            r_addr <= r_addr + 1'b1;
         end
         if (w_accept) begin
            r_err <= 1'b0;
         end else if (w_reject || (r_l0_wr && i_l0_full)) begin
            r_err <= 1'b1;
         end
      end
   end

   assign o_mem_rd   = w_mem_rd;
   assign o_mem_addr = r_addr;
   assign o_l0_wr    = r_l0_wr;
   assign o_l0_rd    = w_l0_rd;
   assign o_busy     = (r_state != StIdle);
   assign o_done     = (r_state == StDone);
   assign o_err      = r_err;

endmodule
